// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, branch-target adder, destination select,
// and an iterative 32-step signed multiply/divide unit with HI/LO registers.
// Optional feature macro: EX_OVERFLOW_TRAP_EN (adds Ovf_Ex signed-overflow flag).
module ex_stage #(
    parameter int unsigned     WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Valid_Ex,
    input  logic [3:0]       ALUCtl_Ex,
    input  logic             ALUSrc_Ex,
    input  logic             RegDst_Ex,
    input  logic [WIDTH-1:0] ADD1_Ex,
    input  logic [WIDTH-1:0] RData1_Ex,
    input  logic [WIDTH-1:0] RData2_Ex,
    input  logic [WIDTH-1:0] SingExtend_Ex,
    input  logic [4:0]       Ins20_16_Ex,
    input  logic [4:0]       Ins15_11_Ex,
    output logic [WIDTH-1:0] ALURes_Ex,
    output logic             Zero_Ex,
    output logic [WIDTH-1:0] BranchAddr_Ex,
    output logic [WIDTH-1:0] WriteData_Ex,
    output logic [4:0]       WriteReg_Ex,
    output logic             Stall_Ex,
    output logic             Busy_Ex
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    output logic             Ovf_Ex
`endif
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  b_op, alu_res, hi, lo, opb, a_mag, b_mag;
    logic [4:0]        shamt;
    logic [DW-1:0]     acc, step_acc, mul_step, div_step, mul_res;
    logic [WIDTH:0]    mul_sum, rem_sh;
    logic [WIDTH-1:0]  rem_sub, quo, rem, fin_hi, fin_lo;
    logic              rem_ge;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, neg_lo, neg_hi;
    logic              op_muldiv, op_div, div_zero;
    logic              load, div0_load;

    assign b_op          = ALUSrc_Ex ? SingExtend_Ex : RData2_Ex;
    assign shamt         = SingExtend_Ex[10:6];
    assign BranchAddr_Ex = ADD1_Ex + {SingExtend_Ex[WIDTH-3:0], 2'b00};
    assign WriteData_Ex  = RData2_Ex;
    assign WriteReg_Ex   = RegDst_Ex ? Ins15_11_Ex : Ins20_16_Ex;
    assign ALURes_Ex     = alu_res;
    assign Zero_Ex       = (alu_res == '0);
    assign Busy_Ex       = (state != IDLE);

    assign op_div    = (ALUCtl_Ex == OP_DIV);
    assign op_muldiv = Valid_Ex && ((ALUCtl_Ex == OP_MULT) || op_div);
    assign div_zero  = op_div && (RData2_Ex == '0);
    assign a_mag     = RData1_Ex[WIDTH-1] ? -RData1_Ex : RData1_Ex;
    assign b_mag     = RData2_Ex[WIDTH-1] ? -RData2_Ex : RData2_Ex;

    // ALU result select; MULT/DIV and unused codes return zero
    always_comb begin
        alu_res = '0;
        case (ALUCtl_Ex)
            OP_AND:  alu_res = RData1_Ex & b_op;
            OP_OR:   alu_res = RData1_Ex | b_op;
            OP_ADD:  alu_res = RData1_Ex + b_op;
            OP_XOR:  alu_res = RData1_Ex ^ b_op;
            OP_SUB:  alu_res = RData1_Ex - b_op;
            OP_SLT:  alu_res = WIDTH'($signed(RData1_Ex) < $signed(b_op));
            OP_NOR:  alu_res = ~(RData1_Ex | b_op);
            OP_SLL:  alu_res = b_op << shamt;
            OP_SRL:  alu_res = b_op >> shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Multiply/divide FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and stall; divide-by-zero bypasses BUSY entirely
    always_comb begin
        state_next = state;
        Stall_Ex   = 1'b0;
        load       = 1'b0;
        div0_load  = 1'b0;
        case (state)
            IDLE: begin
                if (op_muldiv) begin
                    Stall_Ex = 1'b1;
                    if (div_zero) begin
                        div0_load  = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                Stall_Ex = 1'b1;
                if (cnt == LAST_STEP) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One radix-2 step on magnitudes: shift-add multiply or restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_step = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opb});
        rem_sub  = rem_sh[WIDTH-1:0] - opb;
        div_step = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        step_acc = is_div ? div_step : mul_step;
    end

    // Sign correction of the final step into HI/LO form
    always_comb begin
        mul_res = neg_lo ? -step_acc : step_acc;
        quo     = step_acc[WIDTH-1:0];
        rem     = step_acc[DW-1:WIDTH];
        fin_lo  = is_div ? (neg_lo ? -quo : quo) : mul_res[WIDTH-1:0];
        fin_hi  = is_div ? (neg_hi ? -rem : rem) : mul_res[DW-1:WIDTH];
    end

    // Operand latch, iteration and HI/LO update
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (load) begin
                acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                opb    <= op_div ? b_mag : a_mag;
                cnt    <= '0;
                is_div <= op_div;
                neg_lo <= RData1_Ex[WIDTH-1] ^ RData2_Ex[WIDTH-1];
                neg_hi <= RData1_Ex[WIDTH-1];
            end else if (state == BUSY) begin
                acc <= step_acc;
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
            end
            if (div0_load) begin
                hi <= RData1_Ex;
                lo <= DIV0_LO;
            end
        end
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic [WIDTH-1:0] sum_add, sum_sub;
    logic             add_ovf, sub_ovf, div_ovf;

    assign sum_add = RData1_Ex + b_op;
    assign sum_sub = RData1_Ex - b_op;
    assign add_ovf = (RData1_Ex[WIDTH-1] == b_op[WIDTH-1]) && (sum_add[WIDTH-1] != RData1_Ex[WIDTH-1]);
    assign sub_ovf = (RData1_Ex[WIDTH-1] != b_op[WIDTH-1]) && (sum_sub[WIDTH-1] != RData1_Ex[WIDTH-1]);

    // Remember a most-negative / -1 divide so the flag can pulse in DONE
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_ovf <= 1'b0;
        end else if (load || div0_load) begin
            div_ovf <= load && op_div && (RData1_Ex == {1'b1, {(WIDTH-1){1'b0}}})
                       && (RData2_Ex == '1);
        end
    end

    assign Ovf_Ex = (Valid_Ex && (((ALUCtl_Ex == OP_ADD) && add_ovf) ||
                                  ((ALUCtl_Ex == OP_SUB) && sub_ovf)))
                    || ((state == DONE) && div_ovf);
`else
    // Without the trap, most-negative / -1 wraps through the normal sign correction.
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_BAD  = 4'b1101;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Valid_Ex = 1'b0;
    logic [3:0]  ALUCtl_Ex = 4'b0;
    logic        ALUSrc_Ex = 1'b0;
    logic        RegDst_Ex = 1'b0;
    logic [31:0] ADD1_Ex = 32'h0;
    logic [31:0] RData1_Ex = 32'h0;
    logic [31:0] RData2_Ex = 32'h0;
    logic [31:0] SingExtend_Ex = 32'h0;
    logic [4:0]  Ins20_16_Ex = 5'd0;
    logic [4:0]  Ins15_11_Ex = 5'd0;
    logic [31:0] ALURes_Ex, BranchAddr_Ex, WriteData_Ex;
    logic        Zero_Ex, Stall_Ex, Busy_Ex;
    logic [4:0]  WriteReg_Ex;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        Ovf_Ex;
`endif

    int checks   = 0;
    int failures = 0;

    ex_stage dut (
        .Clk(Clk), .Rst(Rst), .Valid_Ex(Valid_Ex), .ALUCtl_Ex(ALUCtl_Ex),
        .ALUSrc_Ex(ALUSrc_Ex), .RegDst_Ex(RegDst_Ex), .ADD1_Ex(ADD1_Ex),
        .RData1_Ex(RData1_Ex), .RData2_Ex(RData2_Ex), .SingExtend_Ex(SingExtend_Ex),
        .Ins20_16_Ex(Ins20_16_Ex), .Ins15_11_Ex(Ins15_11_Ex), .ALURes_Ex(ALURes_Ex),
        .Zero_Ex(Zero_Ex), .BranchAddr_Ex(BranchAddr_Ex), .WriteData_Ex(WriteData_Ex),
        .WriteReg_Ex(WriteReg_Ex), .Stall_Ex(Stall_Ex), .Busy_Ex(Busy_Ex)
`ifdef EX_OVERFLOW_TRAP_EN
        , .Ovf_Ex(Ovf_Ex)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic set_ins(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic src);
        Valid_Ex      = v;
        ALUCtl_Ex     = op;
        RData1_Ex     = a;
        RData2_Ex     = b;
        SingExtend_Ex = imm;
        ALUSrc_Ex     = src;
    endtask

    // Issue a MULT/DIV, hold it while stalled, then read HI and LO back with MFHI/MFLO
    task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int stall_cnt, output logic done_busy,
                              output logic [31:0] hi_v, output logic [31:0] lo_v,
                              output logic timeout);
        @(posedge Clk); #1;
        set_ins(1'b1, op, a, b, 32'h0, 1'b0);
        stall_cnt = 0;
        timeout   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Stall_Ex) begin
                stall_cnt++;
            end else begin
                timeout = 1'b0;
                break;
            end
            @(posedge Clk); #1;
        end
        done_busy = Busy_Ex;
        @(posedge Clk); #1;
        set_ins(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        hi_v = ALURes_Ex;
        @(posedge Clk); #1;
        set_ins(1'b1, OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        lo_v = ALURes_Ex;
        @(posedge Clk); #1;
        Valid_Ex = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (Stall_Ex !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall_Ex); end
        checks++;
        if (Busy_Ex !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy_Ex); end
        @(posedge Clk); #1;
        set_ins(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        checks++;
        if (ALURes_Ex !== 32'h0) begin failures++; $display("FAIL reset_mfhi got=%h exp=0", ALURes_Ex); end
        @(posedge Clk); #1;
        ALUCtl_Ex = OP_MFLO;
        @(negedge Clk);
        checks++;
        if (ALURes_Ex !== 32'h0) begin failures++; $display("FAIL reset_mflo got=%h exp=0", ALURes_Ex); end
    endtask

    task automatic test_alu;
        @(posedge Clk); #1;
        set_ins(1'b1, OP_ADD, 32'd5, 32'h0, 32'hFFFF_FFFD, 1'b1);
        ADD1_Ex = 32'h100;
        @(negedge Clk);
        checks++;
        if (ALURes_Ex !== 32'd2) begin failures++; $display("FAIL add_res got=%h exp=2", ALURes_Ex); end
        checks++;
        if (Zero_Ex !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", Zero_Ex); end
        checks++;
        if (BranchAddr_Ex !== 32'h0000_00F4) begin failures++; $display("FAIL branch_neg got=%h exp=000000f4", BranchAddr_Ex); end

        set_ins(1'b1, OP_SUB, 32'd7, 32'd7, 32'd4, 1'b0);
        RegDst_Ex = 1'b1; Ins15_11_Ex = 5'd9; Ins20_16_Ex = 5'd3;
        #1;
        checks++;
        if (ALURes_Ex !== 32'd0) begin failures++; $display("FAIL sub_res got=%h exp=0", ALURes_Ex); end
        checks++;
        if (Zero_Ex !== 1'b1) begin failures++; $display("FAIL sub_zero got=%b exp=1", Zero_Ex); end
        checks++;
        if (BranchAddr_Ex !== 32'h110) begin failures++; $display("FAIL branch got=%h exp=110", BranchAddr_Ex); end
        checks++;
        if (WriteReg_Ex !== 5'd9) begin failures++; $display("FAIL wreg_rd got=%0d exp=9", WriteReg_Ex); end
        checks++;
        if (WriteData_Ex !== 32'd7) begin failures++; $display("FAIL wdata got=%h exp=7", WriteData_Ex); end
        RegDst_Ex = 1'b0;
        #1;
        checks++;
        if (WriteReg_Ex !== 5'd3) begin failures++; $display("FAIL wreg_rt got=%0d exp=3", WriteReg_Ex); end

        set_ins(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
        #1;
        checks++;
        if (ALURes_Ex !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", ALURes_Ex); end
        set_ins(1'b1, OP_SLL, 32'h0, 32'd1, 32'h0000_0100, 1'b0);
        #1;
        checks++;
        if (ALURes_Ex !== 32'd16) begin failures++; $display("FAIL sll got=%h exp=10", ALURes_Ex); end
        set_ins(1'b1, OP_NOR, 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 1'b0);
        #1;
        checks++;
        if (ALURes_Ex !== 32'hF0F0_FF0F) begin failures++; $display("FAIL nor got=%h exp=f0f0ff0f", ALURes_Ex); end
        set_ins(1'b1, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 1'b0);
        #1;
        checks++;
        if (ALURes_Ex !== 32'h0F00_0F00) begin failures++; $display("FAIL and got=%h exp=0f000f00", ALURes_Ex); end
        set_ins(1'b1, OP_BAD, 32'h1234_5678, 32'h1, 32'h0, 1'b0);
        #1;
        checks++;
        if (ALURes_Ex !== 32'h0) begin failures++; $display("FAIL bad_op got=%h exp=0", ALURes_Ex); end
    endtask

    task automatic test_valid_low;
        @(posedge Clk); #1;
        set_ins(1'b0, OP_MULT, 32'd3, 32'd4, 32'h0, 1'b0);
        @(negedge Clk);
        checks++;
        if (Stall_Ex !== 1'b0) begin failures++; $display("FAIL novalid_stall got=%b exp=0", Stall_Ex); end
        @(posedge Clk); #1;
        checks++;
        if (Busy_Ex !== 1'b0) begin failures++; $display("FAIL novalid_busy got=%b exp=0", Busy_Ex); end
    endtask

    task automatic test_muldiv;
        int          st;
        logic        db, to;
        logic [31:0] h, l;
        // MULT -3 * 7 = -21
        run_muldiv(OP_MULT, 32'hFFFF_FFFD, 32'd7, st, db, h, l, to);
        checks++;
        if (to) begin failures++; $display("FAIL mult_timeout stall never dropped"); end
        checks++;
        if (st !== 33) begin failures++; $display("FAIL mult_stall got=%0d exp=33", st); end
        checks++;
        if (db !== 1'b1) begin failures++; $display("FAIL mult_done_busy got=%b exp=1", db); end
        checks++;
        if (h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
        checks++;
        if (l !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", l); end
        // DIV 100 / -7 = -14 rem 2
        run_muldiv(OP_DIV, 32'd100, 32'hFFFF_FFF9, st, db, h, l, to);
        checks++;
        if (st !== 33 || to) begin failures++; $display("FAIL div_stall got=%0d exp=33", st); end
        checks++;
        if (l !== 32'hFFFF_FFF2) begin failures++; $display("FAIL div_lo got=%h exp=fffffff2", l); end
        checks++;
        if (h !== 32'd2) begin failures++; $display("FAIL div_hi got=%h exp=2", h); end
        // DIV -100 / 7 = -14 rem -2
        run_muldiv(OP_DIV, 32'hFFFF_FF9C, 32'd7, st, db, h, l, to);
        checks++;
        if (l !== 32'hFFFF_FFF2) begin failures++; $display("FAIL divn_lo got=%h exp=fffffff2", l); end
        checks++;
        if (h !== 32'hFFFF_FFFE) begin failures++; $display("FAIL divn_hi got=%h exp=fffffffe", h); end
        // MULT 0x12345 * 0x10001 = 0x1_2346_2345
        run_muldiv(OP_MULT, 32'h0001_2345, 32'h0001_0001, st, db, h, l, to);
        checks++;
        if (h !== 32'h1 || l !== 32'h2346_2345) begin failures++; $display("FAIL mult_big got=%h_%h exp=00000001_23462345", h, l); end
        // Most-negative / -1 wraps
        run_muldiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, db, h, l, to);
        checks++;
        if (l !== 32'h8000_0000 || h !== 32'h0) begin failures++; $display("FAIL div_minneg got=%h_%h exp=00000000_80000000", h, l); end
        // DIV 9 / 0
        run_muldiv(OP_DIV, 32'd9, 32'd0, st, db, h, l, to);
        checks++;
        if (st !== 1 || to) begin failures++; $display("FAIL div0_stall got=%0d exp=1", st); end
        checks++;
        if (db !== 1'b1) begin failures++; $display("FAIL div0_done_busy got=%b exp=1", db); end
        checks++;
        if (l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", l); end
        checks++;
        if (h !== 32'd9) begin failures++; $display("FAIL div0_hi got=%h exp=9", h); end
    endtask

    task automatic test_reset_mid;
        int          st;
        logic        db, to;
        logic [31:0] h, l;
        @(posedge Clk); #1;
        set_ins(1'b1, OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
        repeat (11) @(posedge Clk);
        #1;
        checks++;
        if (Busy_Ex !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", Busy_Ex); end
        Rst = 1'b1;
        Valid_Ex = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        set_ins(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge Clk);
        checks++;
        if (Stall_Ex !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", Stall_Ex); end
        checks++;
        if (Busy_Ex !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", Busy_Ex); end
        checks++;
        if (ALURes_Ex !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", ALURes_Ex); end
        @(posedge Clk); #1;
        ALUCtl_Ex = OP_MFLO;
        @(negedge Clk);
        checks++;
        if (ALURes_Ex !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", ALURes_Ex); end
        run_muldiv(OP_MULT, 32'd2, 32'd3, st, db, h, l, to);
        checks++;
        if (st !== 33 || to) begin failures++; $display("FAIL post_rst_stall got=%0d exp=33", st); end
        checks++;
        if (l !== 32'd6 || h !== 32'd0) begin failures++; $display("FAIL post_rst_mult got=%h_%h exp=00000000_00000006", h, l); end
    endtask

`ifdef EX_OVERFLOW_TRAP_EN
    task automatic test_overflow;
        logic seen;
        @(posedge Clk); #1;
        set_ins(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h0, 1'b0);
        #1;
        checks++;
        if (Ovf_Ex !== 1'b1) begin failures++; $display("FAIL ovf_add got=%b exp=1", Ovf_Ex); end
        checks++;
        if (ALURes_Ex !== 32'h8000_0000) begin failures++; $display("FAIL ovf_add_res got=%h exp=80000000", ALURes_Ex); end
        set_ins(1'b1, OP_ADD, 32'd1, 32'd1, 32'h0, 1'b0);
        #1;
        checks++;
        if (Ovf_Ex !== 1'b0) begin failures++; $display("FAIL ovf_none got=%b exp=0", Ovf_Ex); end
        set_ins(1'b1, OP_SUB, 32'h8000_0000, 32'd1, 32'h0, 1'b0);
        #1;
        checks++;
        if (Ovf_Ex !== 1'b1) begin failures++; $display("FAIL ovf_sub got=%b exp=1", Ovf_Ex); end
        Valid_Ex = 1'b0;
        #1;
        checks++;
        if (Ovf_Ex !== 1'b0) begin failures++; $display("FAIL ovf_invalid got=%b exp=0", Ovf_Ex); end
        @(posedge Clk); #1;
        set_ins(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!Stall_Ex) begin
                seen = Ovf_Ex;
                break;
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL ovf_div got=%b exp=1", seen); end
        @(posedge Clk); #1;
        Valid_Ex = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_valid_low();
        test_muldiv();
        test_reset_mid();
`ifdef EX_OVERFLOW_TRAP_EN
        test_overflow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
